// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader for the CPU instruction RAM
//
// Receives frames of the form SYNC_BYTE, LEN (0 = 256), LEN payload bytes, CSUM
// and writes the payload into instruction RAM starting at BASE_ADDR. The CPU
// is held in reset while a load is in progress and is released only when the
// payload plus CSUM sums to zero mod 256.
//
// Ports
//   _iClk, _iReset_n   clock, synchronous active-low reset
//   _iRxData/_iRxValid incoming byte stream
//   _oRxReady          byte accepted when _iRxValid & _oRxReady
//   _oInstMemW*        instruction RAM write port (address, data, strobe)
//   _oCpuReset         active-high reset to the CPU
//   _oLoadDone         one-cycle pulse when a frame is accepted
//   _oLoadError        sticky bad-checksum / timeout flag, cleared on next SYNC_BYTE
module imem_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter logic [7:0] BASE_ADDR      = 8'h00,
    parameter int         TIMEOUT_CYCLES = 1000,
    parameter bit         BOOT_HOLD      = 1'b1
) (
    input  logic       _iClk,
    input  logic       _iReset_n,
    input  logic [7:0] _iRxData,
    input  logic       _iRxValid,
    output logic       _oRxReady,
    output logic [7:0] _oInstMemWAddr,
    output logic [7:0] _oInstMemWData,
    output logic       _oInstMemWrite,
    output logic       _oCpuReset,
    output logic       _oLoadDone,
    output logic       _oLoadError
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEN  = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          rx_ready_q, rx_ready_d;
    logic [7:0]    waddr_q, waddr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          write_q, write_d;
    logic          cpu_reset_q, cpu_reset_d;
    logic          load_done_q, load_done_d;
    logic          load_error_q, load_error_d;
    logic [8:0]    len_q, len_d;
    logic [8:0]    idx_q, idx_d;
    logic [7:0]    sum_q, sum_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          accept;
    logic [7:0]    csum_total;
    logic [8:0]    idx_next;

    assign accept     = _iRxValid && rx_ready_q;
    assign csum_total = sum_q + _iRxData;
    assign idx_next   = idx_q + 9'd1;

    always_ff @(posedge _iClk) begin
        if (!_iReset_n) begin
            state_q      <= ST_IDLE;
            rx_ready_q   <= 1'b0;
            waddr_q      <= 8'h00;
            wdata_q      <= 8'h00;
            write_q      <= 1'b0;
            cpu_reset_q  <= BOOT_HOLD;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            len_q        <= 9'd0;
            idx_q        <= 9'd0;
            sum_q        <= 8'h00;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            rx_ready_q   <= rx_ready_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            cpu_reset_q  <= cpu_reset_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            sum_q        <= sum_d;
            tmo_q        <= tmo_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rx_ready_d   = 1'b1;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        write_d      = 1'b0;
        cpu_reset_d  = cpu_reset_q;
        load_done_d  = 1'b0;
        load_error_d = load_error_q;
        len_d        = len_q;
        idx_d        = idx_q;
        sum_d        = sum_q;
        tmo_d        = '0;

        // Idle-cycle counter only runs inside a frame and restarts on every byte.
        if (state_q != ST_IDLE && !accept) begin
            tmo_d = tmo_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept && _iRxData == SYNC_BYTE) begin
                    state_d      = ST_LEN;
                    cpu_reset_d  = 1'b1;
                    load_error_d = 1'b0;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    len_d   = (_iRxData == 8'h00) ? 9'd256 : {1'b0, _iRxData};
                    idx_d   = 9'd0;
                    sum_d   = 8'h00;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    write_d    = 1'b1;
                    waddr_d    = BASE_ADDR + idx_q[7:0];
                    wdata_d    = _iRxData;
                    idx_d      = idx_next;
                    sum_d      = csum_total;
                    // Bubble after each payload byte paces the RAM writes.
                    rx_ready_d = 1'b0;
                    if (idx_next == len_q) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    if (csum_total == 8'h00) begin
                        cpu_reset_d = 1'b0;
                        load_done_d = 1'b1;
                    end else begin
                        load_error_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Timeout abandons the frame; the CPU stays held in reset.
        if (state_q != ST_IDLE && !accept && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            load_error_d = 1'b1;
            state_d      = ST_IDLE;
        end
    end

    assign _oRxReady      = rx_ready_q;
    assign _oInstMemWAddr = waddr_q;
    assign _oInstMemWData = wdata_q;
    assign _oInstMemWrite = write_q;
    assign _oCpuReset     = cpu_reset_q;
    assign _oLoadDone     = load_done_q;
    assign _oLoadError    = load_error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;

    logic       ready_a, wr_a, cpurst_a, done_a, err_a;
    logic [7:0] addr_a, data_a;
    logic       ready_b, wr_b, cpurst_b, done_b, err_b;
    logic [7:0] addr_b, data_b;

    imem_loader #(.SYNC_BYTE(8'hA5), .BASE_ADDR(8'h00), .TIMEOUT_CYCLES(TMO), .BOOT_HOLD(1'b1)) u_a (
        ._iClk(clk), ._iReset_n(rst_n), ._iRxData(rx_data), ._iRxValid(rx_valid),
        ._oRxReady(ready_a), ._oInstMemWAddr(addr_a), ._oInstMemWData(data_a),
        ._oInstMemWrite(wr_a), ._oCpuReset(cpurst_a), ._oLoadDone(done_a), ._oLoadError(err_a)
    );

    imem_loader #(.SYNC_BYTE(8'hA5), .BASE_ADDR(8'hF0), .TIMEOUT_CYCLES(TMO), .BOOT_HOLD(1'b0)) u_b (
        ._iClk(clk), ._iReset_n(rst_n), ._iRxData(rx_data), ._iRxValid(rx_valid),
        ._oRxReady(ready_b), ._oInstMemWAddr(addr_b), ._oInstMemWData(data_b),
        ._oInstMemWrite(wr_b), ._oCpuReset(cpurst_b), ._oLoadDone(done_b), ._oLoadError(err_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [15:0] wq_a[$];
    logic [15:0] wq_b[$];
    int done_cnt_a = 0;
    int done_cnt_b = 0;

    always @(negedge clk) begin
        if (wr_a) wq_a.push_back({addr_a, data_a});
        if (wr_b) wq_b.push_back({addr_b, data_b});
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int cnt = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!ready_a && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 50) chk("ready_wait", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic clear_logs();
        wq_a.delete();
        wq_b.delete();
        done_cnt_a = 0;
        done_cnt_b = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, ready_a, 0);
        chk({tag, "_wr"}, wr_a, 0);
        chk({tag, "_addr"}, addr_a, 0);
        chk({tag, "_data"}, data_a, 0);
        chk({tag, "_done"}, done_a, 0);
        chk({tag, "_err"}, err_a, 0);
        chk({tag, "_cpurst_a"}, cpurst_a, 1);
        chk({tag, "_cpurst_b"}, cpurst_b, 0);
    endtask

    typedef struct {
        string       name;
        logic [63:0] bytes;   // byte i at bits [8*i +: 8]
        int          n;
        int          exp_wr;
        logic        exp_err;
        logic        exp_cpurst_a;
        logic        exp_cpurst_b;
        int          exp_done;
    } vec_t;

    vec_t vecs[4];
    logic [7:0] seq[9];
    logic       rlog[4];

    initial begin
        vecs[0] = '{"noise",   64'h0000_0000_0000_FF00, 2, 0, 1'b0, 1'b1, 1'b0, 0};
        vecs[1] = '{"good1",   64'h0000_9A33_2211_03A5, 6, 3, 1'b0, 1'b0, 1'b0, 1};
        vecs[2] = '{"badsum",  64'h0000_0000_0201_02A5, 5, 2, 1'b1, 1'b1, 1'b1, 0};
        vecs[3] = '{"good2",   64'h0000_9A33_2211_03A5, 6, 3, 1'b0, 1'b0, 1'b0, 1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", ready_a, 1);

        // Frame-level vectors
        for (int v = 0; v < 4; v++) begin
            int errs_a = 0;
            int errs_b = 0;
            clear_logs();
            for (int i = 0; i < vecs[v].n; i++) send_byte(vecs[v].bytes[8*i +: 8]);
            repeat (3) @(negedge clk);
            chk({vecs[v].name, "_nwr_a"}, wq_a.size(), vecs[v].exp_wr);
            chk({vecs[v].name, "_nwr_b"}, wq_b.size(), vecs[v].exp_wr);
            for (int i = 0; i < vecs[v].exp_wr && i < wq_a.size() && i < wq_b.size(); i++) begin
                logic [7:0] pb;
                logic [7:0] ia;
                pb = vecs[v].bytes[8*(i+2) +: 8];
                ia = 8'(i);
                if (wq_a[i] !== {ia, pb}) errs_a++;
                if (wq_b[i] !== {8'hF0 + ia, pb}) errs_b++;
            end
            chk({vecs[v].name, "_wcontent_a"}, errs_a, 0);
            chk({vecs[v].name, "_wcontent_b"}, errs_b, 0);
            chk({vecs[v].name, "_err_a"}, err_a, vecs[v].exp_err);
            chk({vecs[v].name, "_err_b"}, err_b, vecs[v].exp_err);
            chk({vecs[v].name, "_cpurst_a"}, cpurst_a, vecs[v].exp_cpurst_a);
            chk({vecs[v].name, "_cpurst_b"}, cpurst_b, vecs[v].exp_cpurst_b);
            chk({vecs[v].name, "_done_a"}, done_cnt_a, vecs[v].exp_done);
            chk({vecs[v].name, "_done_b"}, done_cnt_b, vecs[v].exp_done);
        end

        // Throttle with valid held high, IDLE noise, and A5 as payload
        seq = '{8'h00, 8'hFF, 8'hA5, 8'h04, 8'h01, 8'hA5, 8'h02, 8'h03, 8'h55};
        clear_logs();
        begin
            int k = 0;
            int nlog = 0;
            logic acc;
            @(negedge clk);
            rx_valid = 1'b1;
            for (int c = 0; c < 60 && k < 9; c++) begin
                rx_data = seq[k];
                if (k >= 4 && nlog < 4) begin
                    rlog[nlog] = ready_a;
                    nlog++;
                end
                acc = ready_a;
                @(negedge clk);
                if (acc) k++;
            end
            rx_valid = 1'b0;
            chk("thr_all_sent", k, 9);
        end
        chk("thr_ready_pat", {rlog[0], rlog[1], rlog[2], rlog[3]}, 4'b1010);
        repeat (3) @(negedge clk);
        chk("thr_nwr", wq_a.size(), 4);
        if (wq_a.size() >= 2) chk("thr_a5_written", wq_a[1], 16'h01A5);
        chk("thr_done", done_cnt_a, 1);
        chk("thr_err", err_a, 0);

        // Timeout: A5,02,10 then silence
        clear_logs();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h10);
        repeat (TMO - 1) @(posedge clk);
        #1;
        chk("tmo_not_early", err_a, 0);
        @(posedge clk);
        #1;
        chk("tmo_err", err_a, 1);
        chk("tmo_nwr", wq_a.size(), 1);
        chk("tmo_cpurst_a", cpurst_a, 1);
        chk("tmo_cpurst_b", cpurst_b, 1);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h7F);
        send_byte(8'h81);
        repeat (2) @(negedge clk);
        chk("tmo_recover_done", done_cnt_a, 1);
        chk("tmo_recover_err", err_a, 0);

        // Wrap with LEN=0 (256 bytes of 01, CSUM 00)
        clear_logs();
        send_byte(8'hA5);
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) send_byte(8'h01);
        send_byte(8'h00);
        repeat (3) @(negedge clk);
        chk("wrap_nwr_b", wq_b.size(), 256);
        begin
            int e = 0;
            for (int i = 0; i < wq_b.size(); i++) begin
                logic [7:0] ea;
                ea = 8'hF0 + 8'(i);
                if (wq_b[i] !== {ea, 8'h01}) e++;
            end
            chk("wrap_addr_b", e, 0);
        end
        if (wq_b.size() == 256) begin
            chk("wrap_b_16", wq_b[16][15:8], 8'h00);
            chk("wrap_b_last", wq_b[255][15:8], 8'hEF);
        end
        chk("wrap_done_b", done_cnt_b, 1);
        chk("wrap_cpurst_b", cpurst_b, 0);

        // Reset mid-frame after 2 of 4 payload bytes
        clear_logs();
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        send_byte(8'hCC);
        send_byte(8'hDD);
        repeat (2) @(negedge clk);
        chk("midrst_nwr", wq_a.size(), 0);
        chk("midrst_cpurst_a", cpurst_a, 1);
        chk("midrst_done", done_cnt_a, 0);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h7F);
        send_byte(8'h81);
        repeat (2) @(negedge clk);
        chk("midrst_reload_done", done_cnt_a, 1);
        chk("midrst_reload_cpurst", cpurst_a, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
